// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter for the MemOrIO I/O bus.
// A circular FIFO buffers CPU writes; a four-state serializer drains it LSB first.
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        uartcs,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [1:0]  uartaddr,
  input  logic [7:0]  uart_wdata,
  output logic [15:0] uart_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [2:0]     r_bit, w_bit_nx;
  logic [7:0]     r_shift, w_shift_nx;
  logic           r_tx, w_tx_nx;
  logic           w_pop;

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;

  logic           w_push_req, w_push_ok, w_full, w_nonempty, w_rd_status, w_ovf_event, w_cnt_end;

  assign w_push_req  = uartcs & uartwrite & (uartaddr == 2'b00);
  assign w_rd_status = uartcs & uartread & (uartaddr == 2'b10);
  assign w_full      = (r_count == CNT_FULL);
  assign w_nonempty  = (r_count != {(AW + 1){1'b0}});
  // A full FIFO still accepts a push when the serializer pops at the same edge.
  assign w_push_ok   = w_push_req & (~w_full | w_pop);
  assign w_ovf_event = w_push_req & w_full & ~w_pop;
  assign w_cnt_end   = (r_cnt == CNT_MAX);

  assign busy       = (r_state != S_IDLE) | w_nonempty;
  assign tx         = r_tx;
  assign uart_rdata = w_rd_status ? {13'b0, r_overflow, w_full, busy} : 16'h0000;

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= uart_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {(AW + 1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      // A new overflow wins over a simultaneous status read.
      if (w_ovf_event)      r_overflow <= 1'b1;
      else if (w_rd_status) r_overflow <= 1'b0;
      else                  r_overflow <= r_overflow;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (w_nonempty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rd_ptr];
          w_tx_nx    = 1'b0;
          w_cnt_nx   = {CW{1'b0}};
          w_state_nx = S_START;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (w_cnt_end) begin
          w_cnt_nx   = {CW{1'b0}};
          w_tx_nx    = r_shift[0];
          w_bit_nx   = 3'd0;
          w_state_nx = S_DATA;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_end) begin
          w_cnt_nx = {CW{1'b0}};
          if (r_bit == 3'd7) begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_tx_nx    = r_shift[1];
            w_bit_nx   = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_end) begin
          w_cnt_nx = {CW{1'b0}};
          // Back-to-back frames: next start bit follows the stop bit directly.
          if (w_nonempty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rd_ptr];
            w_tx_nx    = 1'b0;
            w_state_nx = S_START;
          end else begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_tx_nx    = 1'b1;
        w_state_nx = S_IDLE;
      end
    endcase
  end

endmodule
